// File: rtl/comparator_serial_nbit.sv
// comparator_serial_nbit: multi-cycle MSB-first magnitude comparator, CHUNK_WIDTH bits per cycle with early exit
module comparator_serial_nbit #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHUNK_WIDTH = 4
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Start_In,
  input  logic                  Signed_Mode_In,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic                  A_Less_Than_B_Out,
  output logic                  A_Equal_To_B_Out,
  output logic                  A_Greater_Than_B_Out
);
  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);
  localparam logic [DATA_WIDTH-1:0] MSB_MASK = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

  if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_chunk
    $error("CHUNK_WIDTH must divide DATA_WIDTH");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic                    done_q, done_d, lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic [CHUNK_WIDTH-1:0]  chunk_a, chunk_b;
  logic                    chunk_ne, finish;

  // Operands shift left each step, so the chunk under test is always at the top.
  assign chunk_a  = a_q[DATA_WIDTH-1 -: CHUNK_WIDTH];
  assign chunk_b  = b_q[DATA_WIDTH-1 -: CHUNK_WIDTH];
  assign chunk_ne = chunk_a != chunk_b;
  assign finish   = state_q == RUN && (chunk_ne || cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    if (state_q == IDLE && Start_In) begin
      state_d = RUN;
      cnt_d   = '0;
      a_d     = Data_A_In ^ (Signed_Mode_In ? MSB_MASK : '0);
      b_d     = Data_B_In ^ (Signed_Mode_In ? MSB_MASK : '0);
    end else if (finish) begin
      state_d = IDLE;
      done_d  = 1'b1;
      lt_d    = chunk_a < chunk_b;
      gt_d    = chunk_a > chunk_b;
      eq_d    = !chunk_ne;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
      a_d   = a_q << CHUNK_WIDTH;
      b_d   = b_q << CHUNK_WIDTH;
    end
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign Busy_Out             = state_q == RUN;
  assign Done_Out             = done_q;
  assign A_Less_Than_B_Out    = lt_q;
  assign A_Equal_To_B_Out     = eq_q;
  assign A_Greater_Than_B_Out = gt_q;
endmodule

// File: tb/tb_comparator_serial_nbit.sv
// tb_comparator_serial_nbit: scoreboard bench; stimulus pushes expected flags and done cycle, monitor pops on Done_Out
module tb_comparator_serial_nbit;
  logic        clk = 1'b0;
  logic        Reset_In = 1'b1;
  logic        Start_In = 1'b0;
  logic        Signed_Mode_In = 1'b0;
  logic [15:0] Data_A_In = '0;
  logic [15:0] Data_B_In = '0;
  logic        Busy_Out, Done_Out, A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out;

  comparator_serial_nbit #(.DATA_WIDTH(16), .CHUNK_WIDTH(4)) dut (
    .Clock_In(clk),
    .Reset_In(Reset_In),
    .Start_In(Start_In),
    .Signed_Mode_In(Signed_Mode_In),
    .Data_A_In(Data_A_In),
    .Data_B_In(Data_B_In),
    .Busy_Out(Busy_Out),
    .Done_Out(Done_Out),
    .A_Less_Than_B_Out(A_Less_Than_B_Out),
    .A_Equal_To_B_Out(A_Equal_To_B_Out),
    .A_Greater_Than_B_Out(A_Greater_Than_B_Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] f;
    int         c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [2:0] last_f = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  // Flags are {LT, EQ, GT}; on non-done cycles they must hold the last result.
  always @(negedge clk) begin
    logic [2:0] f;
    exp_t e;
    f = {A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out};
    if (Reset_In) last_f = 3'b000;
    else if (Done_Out) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got Done_Out=1 at cycle %0d, required no pending op", cyc);
      end else begin
        e = q.pop_front();
        if (f !== e.f || cyc != e.c || Busy_Out !== 1'b0) begin
          errors++;
          $display("FAIL result: got flags=%b cycle=%0d busy=%b, required flags=%b cycle=%0d busy=0",
                   f, cyc, Busy_Out, e.f, e.c);
        end
      end
      last_f = f;
    end else begin
      checks++;
      if (f !== last_f) begin
        errors++;
        $display("FAIL hold: got flags=%b, required %b at cycle %0d", f, last_f, cyc);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [2:0] f, input int j);
    Data_A_In = a;
    Data_B_In = b;
    Signed_Mode_In = s;
    Start_In = 1'b1;
    q.push_back('{f, cyc + j + 2});
    @(negedge clk);
    Start_In = 1'b0;
    Data_A_In = ~a;
    Data_B_In = b ^ 16'h5A5A;
    Signed_Mode_In = ~s;
    checks++;
    if (Busy_Out !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b, required 1", Busy_Out);
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = Done_Out;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no Done_Out within 20 cycles, required one");
    end
  endtask

  function automatic int first_diff(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 4; i++)
      if (a[15-4*i -: 4] != b[15-4*i -: 4]) return i;
    return 3;
  endfunction

  function automatic logic [2:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic lt, gt;
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
    gt = s ? ($signed(a) > $signed(b)) : (a > b);
    return {lt, !lt && !gt, gt};
  endfunction

  initial begin
    logic [15:0] a, b;
    logic s;
    int k;
    logic [4:0] o;
    repeat (2) @(negedge clk);
    o = {Busy_Out, Done_Out, A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out};
    checks++;
    if (o !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: got %b, required 00000", o);
    end
    #1 Reset_In = 1'b0;
    @(negedge clk);

    issue(16'h1234, 16'h1234, 1'b0, 3'b010, 3); wait_done();
    issue(16'h8000, 16'h7FFF, 1'b0, 3'b001, 0); wait_done();
    issue(16'h8000, 16'h7FFF, 1'b1, 3'b100, 0); wait_done();
    issue(16'h12F4, 16'h1204, 1'b0, 3'b001, 2); wait_done();
    issue(16'h1204, 16'h12F4, 1'b0, 3'b100, 2); wait_done();

    issue(16'hFFFF, 16'h0000, 1'b1, 3'b100, 0);
    Data_A_In = 16'h0001;
    Data_B_In = 16'h0002;
    Signed_Mode_In = 1'b0;
    Start_In = 1'b1;
    @(negedge clk);
    Start_In = 1'b0;
    checks++;
    if (Done_Out !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_ignored: got Done_Out=%b, required 1", Done_Out);
    end
    issue(16'h0003, 16'h0003, 1'b0, 3'b010, 3); wait_done();

    issue(16'h1234, 16'h1234, 1'b0, 3'b010, 3);
    repeat (2) @(negedge clk);
    #2 Reset_In = 1'b1;
    #1;
    o = {Busy_Out, Done_Out, A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out};
    checks++;
    if (o !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: got %b, required 00000", o);
    end
    q.delete();
    @(negedge clk);
    #1 Reset_In = 1'b0;
    repeat (8) @(negedge clk);
    issue(16'h0005, 16'h0004, 1'b1, 3'b001, 3); wait_done();
    issue(16'h7FFF, 16'h8000, 1'b1, 3'b001, 0); wait_done();
    issue(16'hFFFE, 16'hFFFF, 1'b1, 3'b100, 3); wait_done();

    for (int n = 0; n < 3000; n++) begin
      a = 16'($urandom);
      s = 1'($urandom);
      k = $urandom_range(0, 4);
      b = (k == 4) ? a : a ^ (16'($urandom_range(1, 15)) << (4 * (3 - k)));
      if ($urandom_range(0, 7) == 0) b = 16'($urandom);
      issue(a, b, s, model(a, b, s), first_diff(a, b));
      wait_done();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
